// File: rtl/binary_window_3x3_pkg.sv
// Shared types and helpers for the 1-bit 3x3 window generator and its downstream consumers.
// Window bit layout: bit 8 is the top-left pixel (oldest row, oldest column); bit 0 is the newest pixel.
package binary_window_3x3_pkg;

  localparam int WIN_TL = 8;
  localparam int WIN_TC = 7;
  localparam int WIN_TR = 6;
  localparam int WIN_ML = 5;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 3;
  localparam int WIN_BL = 2;
  localparam int WIN_BC = 1;
  localparam int WIN_BR = 0;

  // Packs as {top, mid, bot}, so top[2] lands on WIN_TL and bot[0] on WIN_BR.
  typedef struct packed {
    logic [2:0] top;
    logic [2:0] mid;
    logic [2:0] bot;
  } window_rows_t;

  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic window_rows_t shift_in(input window_rows_t rows,
                                            input logic top_px,
                                            input logic mid_px,
                                            input logic bot_px);
    window_rows_t res;
    res.top = {rows.top[1:0], top_px};
    res.mid = {rows.mid[1:0], mid_px};
    res.bot = {rows.bot[1:0], bot_px};
    return res;
  endfunction

endpackage

// File: rtl/binary_window_3x3_line_ram.sv
// 1-bit line RAM with registered read and a write that commits one cycle after its address.
// DataIn is sampled in the cycle after Addr/WriteEnable; a same-cycle read returns the old data.
module binary_window_3x3_line_ram
  import binary_window_3x3_pkg::*;
#(
  parameter int Depth = 640,
  localparam int AddrWidth = pos_width(Depth)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic [AddrWidth-1:0] Addr,
  input  logic                 WriteEnable,
  input  logic                 DataIn,
  output logic                 DataOut
);

  logic                 mem [Depth];
  logic [AddrWidth-1:0] wr_addr;
  logic                 wr_pending;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wr_addr    <= '0;
      wr_pending <= 1'b0;
    end else begin
      wr_pending <= WriteEnable;
      if (WriteEnable) begin
        wr_addr <= Addr;
      end
    end
  end

  // Read data only moves when a new address is issued, so it survives input gaps.
  always_ff @(posedge Clock) begin
    if (wr_pending) begin
      mem[wr_addr] <= DataIn;
    end
    if (WriteEnable) begin
      DataOut <= mem[Addr];
    end
  end

endmodule

// File: rtl/binary_window_3x3.sv
// Streaming 3x3 neighbourhood generator for binarised raster video.
// Two line RAMs hold rows r-1 and r-2; one window per accepted pixel once row/col history is complete.
module binary_window_3x3
  import binary_window_3x3_pkg::*;
#(
  parameter int ImageWidth  = 640,
  parameter int ImageHeight = 480,
  localparam int AddrWidth  = pos_width(ImageWidth),
  localparam int RowWidth   = pos_width(ImageHeight)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 PixelValid,
  input  logic                 PixelIn,
  input  logic                 FrameStart,
  output logic                 WindowValid,
  output logic [8:0]           Window,
  output logic [AddrWidth-1:0] CentreX,
  output logic [RowWidth-1:0]  CentreY,
  output logic                 FrameDone
);

  localparam logic [AddrWidth-1:0] COL_LAST = AddrWidth'(ImageWidth - 1);
  localparam logic [RowWidth-1:0]  ROW_LAST = RowWidth'(ImageHeight - 1);

  logic [AddrWidth-1:0] col_reg, col_next, acc_col;
  logic [RowWidth-1:0]  row_reg, row_next, acc_row;

  logic                 s1_valid;
  logic                 s1_pix;
  logic [AddrWidth-1:0] s1_col;
  logic [RowWidth-1:0]  s1_row;

  logic                 line0_q;
  logic                 line1_q;

  window_rows_t         rows_reg, rows_next;
  logic                 win_fire;
  logic                 last_pixel;

  // FrameStart overrides whatever position the counters hold.
  always_comb begin
    acc_col  = FrameStart ? '0 : col_reg;
    acc_row  = FrameStart ? '0 : row_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (PixelValid) begin
      if (acc_col == COL_LAST) begin
        col_next = '0;
        row_next = (acc_row == ROW_LAST) ? '0 : acc_row + RowWidth'(1);
      end else begin
        col_next = acc_col + AddrWidth'(1);
        row_next = acc_row;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      col_reg  <= '0;
      row_reg  <= '0;
      s1_valid <= 1'b0;
      s1_pix   <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      col_reg  <= col_next;
      row_reg  <= row_next;
      s1_valid <= PixelValid;
      if (PixelValid) begin
        s1_pix <= PixelIn;
        s1_col <= acc_col;
        s1_row <= acc_row;
      end
    end
  end

  // Line0 holds row r-1, Line1 row r-2; in S2 each rewrites address c one row further down.
  binary_window_3x3_line_ram #(
    .Depth(ImageWidth)
  ) line0 (
    .Clock      (Clock),
    .nReset     (nReset),
    .Addr       (acc_col),
    .WriteEnable(PixelValid),
    .DataIn     (s1_pix),
    .DataOut    (line0_q)
  );

  binary_window_3x3_line_ram #(
    .Depth(ImageWidth)
  ) line1 (
    .Clock      (Clock),
    .nReset     (nReset),
    .Addr       (acc_col),
    .WriteEnable(PixelValid),
    .DataIn     (line0_q),
    .DataOut    (line1_q)
  );

  always_comb begin
    rows_next  = shift_in(rows_reg, line1_q, line0_q, s1_pix);
    win_fire   = s1_valid && (s1_row >= RowWidth'(2)) && (s1_col >= AddrWidth'(2));
    last_pixel = (s1_row == ROW_LAST) && (s1_col == COL_LAST);
  end

  // Window/centre registers only move when a window is emitted, so they hold across gaps.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rows_reg    <= '0;
      WindowValid <= 1'b0;
      Window      <= '0;
      CentreX     <= '0;
      CentreY     <= '0;
      FrameDone   <= 1'b0;
    end else begin
      WindowValid <= win_fire;
      FrameDone   <= win_fire && last_pixel;
      if (s1_valid) begin
        rows_reg <= rows_next;
      end
      if (win_fire) begin
        Window  <= rows_next;
        CentreX <= s1_col - AddrWidth'(1);
        CentreY <= s1_row - RowWidth'(1);
      end
    end
  end

endmodule
